// File: rtl/sound_square_ctrl.sv
// Square channel CPU front-end: NRx0..NRx4 register file, trigger pulse
// generation, masked read-back and the 512 Hz frame sequencer.
module sound_square_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'hFF10,
  parameter int unsigned FS_DIV    = 8192,
  parameter int unsigned START_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        wr,
  input  logic        sound_enable,
  output logic [2:0]  sweep_time,
  output logic        sweep_decreasing,
  output logic [2:0]  num_sweep_shifts,
  output logic [1:0]  wave_duty,
  output logic [5:0]  length,
  output logic [3:0]  initial_volume,
  output logic        envelope_increasing,
  output logic [2:0]  num_envelope_sweeps,
  output logic [10:0] frequency,
  output logic        single,
  output logic        start,
  output logic        clk_length_ctr,
  output logic        clk_sweep,
  output logic        clk_vol_env
);

  localparam int unsigned PW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam int unsigned SW = (START_LEN > 0) ? $clog2(START_LEN + 1) : 1;
  localparam logic [7:0]  NR4_STORE = 8'h47;

  logic [7:0]    nr0_q, nr1_q, nr2_q, nr3_q, nr4_q;
  logic [7:0]    nr0_d, nr1_d, nr2_d, nr3_d, nr4_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          start_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    step_q, step_d;
  logic          len_d, swp_d, env_d;
  logic [15:0]   off_c;
  logic          hit_c;
  logic          unused_rd_c;

  // Register offset relative to NRx0; only offsets 0..4 are mapped
  assign off_c       = a - BASE_ADDR;
  assign hit_c       = (off_c < 16'd5);
  assign unused_rd_c = rd;

  // Field views of the stored registers
  assign sweep_time          = nr0_q[6:4];
  assign sweep_decreasing    = nr0_q[3];
  assign num_sweep_shifts    = nr0_q[2:0];
  assign wave_duty           = nr1_q[7:6];
  assign length              = nr1_q[5:0];
  assign initial_volume      = nr2_q[7:4];
  assign envelope_increasing = nr2_q[3];
  assign num_envelope_sweeps = nr2_q[2:0];
  assign frequency           = {nr4_q[2:0], nr3_q};
  assign single              = nr4_q[6];

  // Masked read-back; write-only bits read as 1
  always_comb begin
    dout = 8'hFF;
    if (hit_c) begin
      case (off_c[2:0])
        3'd0:    dout = nr0_q | 8'h80;
        3'd1:    dout = nr1_q | 8'h3F;
        3'd2:    dout = nr2_q;
        3'd3:    dout = 8'hFF;
        3'd4:    dout = nr4_q | 8'hBF;
        default: dout = 8'hFF;
      endcase
    end
  end

  // Next-state: register writes, trigger counter and frame sequencer
  always_comb begin
    nr0_d  = nr0_q;
    nr1_d  = nr1_q;
    nr2_d  = nr2_q;
    nr3_d  = nr3_q;
    nr4_d  = nr4_q;
    cnt_d  = (cnt_q != '0) ? cnt_q - SW'(1) : '0;
    pre_d  = pre_q;
    step_d = step_q;
    len_d  = clk_length_ctr;
    swp_d  = clk_sweep;
    env_d  = clk_vol_env;

    if (!sound_enable) begin
      nr0_d  = '0;
      nr1_d  = '0;
      nr2_d  = '0;
      nr3_d  = '0;
      nr4_d  = '0;
      cnt_d  = '0;
      pre_d  = '0;
      step_d = '0;
      len_d  = 1'b0;
      swp_d  = 1'b0;
      env_d  = 1'b0;
    end else begin
      if (wr && hit_c) begin
        case (off_c[2:0])
          3'd0: nr0_d = din;
          3'd1: nr1_d = din;
          3'd2: nr2_d = din;
          3'd3: nr3_d = din;
          3'd4: begin
            nr4_d = din & NR4_STORE;
            if (din[7]) cnt_d = SW'(START_LEN);
          end
          default: ;
        endcase
      end

      // Step outputs change only on a prescaler wrap, so each stays high for
      // exactly one full step and the first step 0 after restart is silent
      if (pre_q == PW'(FS_DIV - 1)) begin
        pre_d  = '0;
        step_d = step_q + 3'd1;
        len_d  = ~step_d[0];
        swp_d  = (step_d[1:0] == 2'b10);
        env_d  = (step_d == 3'd7);
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    start_d = (cnt_d != '0);
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nr0_q          <= '0;
      nr1_q          <= '0;
      nr2_q          <= '0;
      nr3_q          <= '0;
      nr4_q          <= '0;
      cnt_q          <= '0;
      start          <= 1'b0;
      pre_q          <= '0;
      step_q         <= '0;
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else begin
      nr0_q          <= nr0_d;
      nr1_q          <= nr1_d;
      nr2_q          <= nr2_d;
      nr3_q          <= nr3_d;
      nr4_q          <= nr4_d;
      cnt_q          <= cnt_d;
      start          <= start_d;
      pre_q          <= pre_d;
      step_q         <= step_d;
      clk_length_ctr <= len_d;
      clk_sweep      <= swp_d;
      clk_vol_env    <= env_d;
    end
  end

endmodule

// File: tb/tb_sound_square_ctrl.sv
// Bench for sound_square_ctrl: directed steps plus random bus traffic, checked
// every cycle against a cycle-count based reference model.
module tb_sound_square_ctrl;

  localparam logic [15:0] BASE = 16'hFF10;
  localparam int FS = 16;
  localparam int SL = 4;

  logic        clk, rst;
  logic [15:0] a;
  logic [7:0]  din, dout;
  logic        rd, wr, sound_enable;
  logic [2:0]  sweep_time, num_sweep_shifts, num_envelope_sweeps;
  logic        sweep_decreasing, envelope_increasing, single, start;
  logic [1:0]  wave_duty;
  logic [5:0]  length;
  logic [3:0]  initial_volume;
  logic [10:0] frequency;
  logic        clk_length_ctr, clk_sweep, clk_vol_env;

  sound_square_ctrl #(.BASE_ADDR(BASE), .FS_DIV(FS), .START_LEN(SL)) dut (
    .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout), .rd(rd), .wr(wr),
    .sound_enable(sound_enable), .sweep_time(sweep_time),
    .sweep_decreasing(sweep_decreasing), .num_sweep_shifts(num_sweep_shifts),
    .wave_duty(wave_duty), .length(length), .initial_volume(initial_volume),
    .envelope_increasing(envelope_increasing),
    .num_envelope_sweeps(num_envelope_sweeps), .frequency(frequency),
    .single(single), .start(start), .clk_length_ctr(clk_length_ctr),
    .clk_sweep(clk_sweep), .clk_vol_env(clk_vol_env)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, edge count of last trigger, and the
  // edge count at which the sequencer last restarted from step 0
  logic [7:0] mregs [5];
  int  ecnt = 0;
  int  seq_base = 0;
  int  last_trig = 0;
  bit  trig_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mask_of(input int i);
    case (i)
      0: return 8'h80;
      1: return 8'h3F;
      2: return 8'h00;
      3: return 8'hFF;
      default: return 8'hBF;
    endcase
  endfunction

  function automatic logic [7:0] exp_dout(input logic [15:0] addr);
    int off;
    off = int'(addr) - int'(BASE);
    if (off >= 0 && off < 5) return mregs[off] | mask_of(off);
    return 8'hFF;
  endfunction

  function automatic int seq_n();
    return ecnt - seq_base;
  endfunction

  function automatic int cur_step();
    return (seq_n() / FS) % 8;
  endfunction

  task automatic check_outputs();
    int n, s;
    bit started;
    n = seq_n();
    s = cur_step();
    started = (n >= FS);
    chk("sweep_time",   32'(sweep_time),          32'(mregs[0][6:4]));
    chk("sweep_dec",    32'(sweep_decreasing),    32'(mregs[0][3]));
    chk("sweep_shifts", 32'(num_sweep_shifts),    32'(mregs[0][2:0]));
    chk("wave_duty",    32'(wave_duty),           32'(mregs[1][7:6]));
    chk("length",       32'(length),              32'(mregs[1][5:0]));
    chk("init_vol",     32'(initial_volume),      32'(mregs[2][7:4]));
    chk("env_inc",      32'(envelope_increasing), 32'(mregs[2][3]));
    chk("env_sweeps",   32'(num_envelope_sweeps), 32'(mregs[2][2:0]));
    chk("frequency",    32'(frequency),           32'({mregs[4][2:0], mregs[3]}));
    chk("single",       32'(single),              32'(mregs[4][6]));
    chk("start",        32'(start),
        32'(trig_valid && (ecnt - last_trig) < SL));
    chk("clk_length_ctr", 32'(clk_length_ctr), 32'(started && (s % 2 == 0)));
    chk("clk_sweep",      32'(clk_sweep),      32'(started && (s == 2 || s == 6)));
    chk("clk_vol_env",    32'(clk_vol_env),    32'(started && s == 7));
    chk("dout",           32'(dout),           32'(exp_dout(a)));
  endtask

  // One clock: model absorbs the inputs captured at the coming edge
  task automatic cycle();
    int e, off;
    e = ecnt + 1;
    off = int'(a) - int'(BASE);
    if (!sound_enable) begin
      for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
      trig_valid = 0;
      seq_base = e;
    end else if (wr && off >= 0 && off < 5) begin
      if (off == 4) begin
        mregs[4] = din & 8'h47;
        if (din[7]) begin
          trig_valid = 1;
          last_trig = e;
        end
      end else begin
        mregs[off] = din;
      end
    end
    @(posedge clk);
    #1;
    ecnt = e;
    check_outputs();
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
    a = addr;
    din = data;
    wr = 1'b1;
    cycle();
    wr = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
    trig_valid = 0;
    seq_base = ecnt;
  endtask

  initial begin
    int first_len, first_env, env_hi, sweep_rises, hi;
    bit prev_sweep, reached;

    rst = 1'b1; a = BASE; din = 8'h00; rd = 1'b0; wr = 1'b0; sound_enable = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset state and masked reads
    check_outputs();
    a = 16'hFF10; #1; chk("rd_ff10_reset", 32'(dout), 32'h80);
    a = 16'hFF14; #1; chk("rd_ff14_reset", 32'(dout), 32'hBF);
    a = 16'hFF15; #1; chk("rd_ff15_reset", 32'(dout), 32'hFF);
    rd = 1'b1;
    a = 16'hFF12; #1; chk("rd_ff12_reset", 32'(dout), 32'h00);
    rd = 1'b0;

    // Frame sequencer from reset over one full rotation
    first_len = -1; first_env = -1; env_hi = 0; sweep_rises = 0; prev_sweep = 0;
    while (seq_n() < 8 * FS + 2) begin
      cycle();
      if (clk_length_ctr && first_len < 0) first_len = seq_n();
      if (clk_vol_env && first_env < 0) first_env = seq_n();
      if (clk_vol_env) env_hi++;
      if (clk_sweep && !prev_sweep) sweep_rises++;
      prev_sweep = clk_sweep;
    end
    chk("len_first_rise", 32'(first_len), 32'(2 * FS));
    chk("env_first_high", 32'(first_env), 32'(7 * FS));
    chk("env_high_cycles", 32'(env_hi), 32'(FS));
    chk("sweep_rises", 32'(sweep_rises), 32'd2);

    // Register writes without trigger
    wr_reg(16'hFF11, 8'hC5);
    wr_reg(16'hFF13, 8'h34);
    wr_reg(16'hFF14, 8'h47);
    chk("w_duty", 32'(wave_duty), 32'd3);
    chk("w_length", 32'(length), 32'd5);
    chk("w_freq", 32'(frequency), 32'h734);
    chk("w_single", 32'(single), 32'd1);
    chk("w_start", 32'(start), 32'd0);
    a = 16'hFF11; #1; chk("rd_ff11", 32'(dout), 32'hFF);
    a = 16'hFF14; #1; chk("rd_ff14", 32'(dout), 32'hFF);

    // Single trigger pulse width
    cycle();
    hi = 0;
    wr_reg(16'hFF14, 8'h80);
    chk("trig_first", 32'(start), 32'd1);
    hi += int'(start);
    for (int i = 0; i < 8; i++) begin cycle(); hi += int'(start); end
    chk("trig_width", 32'(hi), 32'(SL));

    // Retrigger two cycles in extends the pulse
    hi = 0;
    wr_reg(16'hFF14, 8'h80); hi += int'(start);
    cycle();                 hi += int'(start);
    wr_reg(16'hFF14, 8'h80); hi += int'(start);
    for (int i = 0; i < 8; i++) begin cycle(); hi += int'(start); end
    chk("retrig_width", 32'(hi), 32'(2 + SL));

    // Random bus traffic with occasional master disable
    for (int i = 0; i < 300; i++) begin
      a = 16'hFF0E + 16'($urandom_range(0, 8));
      din = 8'($urandom);
      wr = 1'($urandom_range(0, 1));
      sound_enable = ($urandom_range(0, 19) != 0);
      cycle();
    end
    wr = 1'b0;
    sound_enable = 1'b1;
    cycle();

    // Master disable in the middle of a start pulse
    wr_reg(16'hFF10, 8'h7F);
    wr_reg(16'hFF12, 8'hA5);
    wr_reg(16'hFF14, 8'hC7);
    cycle();
    chk("pre_off_start", 32'(start), 32'd1);
    sound_enable = 1'b0;
    cycle();
    chk("off_start", 32'(start), 32'd0);
    for (int i = 0; i < 5; i++) begin
      a = BASE + 16'(i); #1;
      chk("off_read", 32'(dout), 32'(mask_of(i)));
    end
    wr_reg(16'hFF12, 8'hF3);
    chk("off_wr_vol", 32'(initial_volume), 32'd0);
    a = 16'hFF12; #1; chk("off_rd_ff12", 32'(dout), 32'h00);
    chk("off_len_clk", 32'(clk_length_ctr), 32'd0);
    sound_enable = 1'b1;
    cycle();

    // Async reset pulse while in step 7 with a trigger in flight
    wr_reg(16'hFF11, 8'hFF);
    reached = 0;
    for (int i = 0; i < 400 && !reached; i++) begin
      cycle();
      reached = (seq_n() >= FS) && (cur_step() == 7) && (seq_n() % FS == FS / 2);
    end
    chk("reach_step7", 32'(reached), 32'd1);
    wr_reg(16'hFF14, 8'h87);
    chk("s7_env", 32'(clk_vol_env), 32'd1);
    chk("s7_start", 32'(start), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ar_env", 32'(clk_vol_env), 32'd0);
    chk("ar_start", 32'(start), 32'd0);
    chk("ar_duty", 32'(wave_duty), 32'd0);
    chk("ar_freq", 32'(frequency), 32'd0);
    a = 16'hFF11; #1; chk("ar_rd_ff11", 32'(dout), 32'h3F);
    rst = 1'b0;
    model_reset();
    first_len = -1;
    while (seq_n() < 3 * FS) begin
      cycle();
      if (clk_length_ctr && first_len < 0) first_len = seq_n();
    end
    chk("ar_len_first_rise", 32'(first_len), 32'(2 * FS));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
